// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multi-cycle RV32I datapath. Instruction fetch and data
// access share one memory port. Every datapath select and strobe is decoded
// from the current state, the IR opcode, the branch comparison result and
// memory readiness.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   opcode            IR[6:0]
//   branch_cond       funct3 comparison result (meaningful in EXEC)
//   mem_ready         memory completes the current access this cycle
//   pc_write          load PC at the clock edge
//   ir_write          load IR and old_pc
//   addr_sel          memory address: 0=PC, 1=ALUOut
//   mem_req, mem_we   memory request / write qualifier
//   alu_a_sel         00=rs1, 01=PC, 10=old_pc, 11=zero
//   alu_b_sel         00=rs2, 01=imm, 10=const 4
//   pc_src            00=ALU result, 01=ALUOut
//   wb_sel            00=ALUOut, 01=MDR, 10=link (old_pc+4)
//   reg_write         register file write
//   instr_retired     pulse on the final cycle of each instruction
//   state_out         FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//   halted, illegal, timeout   sticky status flags, cleared only by reset
//
// Memory handshake: a transfer happens in every cycle where mem_req and
// mem_ready are both 1. mem_req, addr_sel and mem_we come from the state
// register only, so once raised they hold until the cycle that sees
// mem_ready. mem_ready is ignored while mem_req is 0, and completion in the
// first request cycle is allowed.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       addr_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       instr_retired,
  output logic [2:0] state_out,
  output logic       halted,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Value of the stall counter during the last allowed stalled cycle.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  // A stalled request cycle either keeps waiting or, on the last allowed
  // cycle, gives up. mem_ready in that same cycle takes priority.
  logic stall_expired;
  assign stall_expired = (tcnt_q == TCNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      tcnt_q    <= 8'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    halted_d      = halted_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    addr_sel      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    alu_a_sel     = 2'b00;
    alu_b_sel     = 2'b00;
    pc_src        = 2'b00;
    wb_sel        = 2'b00;
    reg_write     = 1'b0;
    instr_retired = 1'b0;

    // Outputs are gated while reset is held so an asynchronous reset
    // cancels any strobe in the cycle it arrives.
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_a_sel = 2'b01;
          alu_b_sel = 2'b10;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (stall_expired) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end
        end

        S_DECODE: begin
          // old_pc + imm is latched in ALUOut as the branch/JAL target.
          alu_a_sel = 2'b10;
          alu_b_sel = 2'b01;
          unique case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
            OP_SYSTEM: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end

        S_EXEC: begin
          unique case (opcode)
            OP_R: state_d = S_WB;
            OP_I: begin
              alu_b_sel = 2'b01;
              state_d   = S_WB;
            end
            OP_LUI: begin
              alu_a_sel = 2'b11;
              alu_b_sel = 2'b01;
              state_d   = S_WB;
            end
            OP_AUIPC: begin
              alu_a_sel = 2'b10;
              alu_b_sel = 2'b01;
              state_d   = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_b_sel = 2'b01;
              state_d   = S_MEM;
            end
            OP_BRANCH: begin
              pc_write      = branch_cond;
              pc_src        = 2'b01;
              instr_retired = 1'b1;
              state_d       = S_FETCH;
            end
            OP_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
              state_d  = S_WB;
            end
            OP_JALR: begin
              // rs1 + imm straight from the ALU; the datapath clears bit 0.
              alu_b_sel = 2'b01;
              pc_write  = 1'b1;
              state_d   = S_WB;
            end
            default: begin
              // IR cannot change after DECODE; treat a surprise as illegal.
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end

        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              instr_retired = 1'b1;
              state_d       = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (stall_expired) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end
        end

        S_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_d       = S_FETCH;
          if (opcode == OP_LOAD) begin
            wb_sel = 2'b01;
          end else if (opcode == OP_JAL || opcode == OP_JALR) begin
            wb_sel = 2'b10;
          end
        end

        S_HALT: state_d = S_HALT;

        default: state_d = S_HALT;
      endcase
    end
  end

  // Counts consecutive stalled request cycles within one state.
  always_comb begin
    tcnt_d = 8'd0;
    if (mem_req && !mem_ready && (state_d == state_q)) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  assign state_out = state_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed and randomized checks of multicycle_ctrl. A responder answers
// memory requests after a chosen number of wait cycles; a per-instruction
// reference model predicts latency and how many cycles each strobe is seen.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, addr_sel, mem_req, mem_we;
  logic [1:0] alu_a_sel, alu_b_sel, pc_src, wb_sel;
  logic       reg_write, instr_retired;
  logic [2:0] state_out;
  logic       halted, illegal, timeout;
  logic [20:0] all_outs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .pc_src(pc_src),
    .wb_sel(wb_sel), .reg_write(reg_write), .instr_retired(instr_retired),
    .state_out(state_out), .halted(halted), .illegal(illegal),
    .timeout(timeout)
  );

  assign all_outs = {pc_write, ir_write, addr_sel, mem_req, mem_we, alu_a_sel,
                     alu_b_sel, pc_src, wb_sel, reg_write, instr_retired,
                     state_out, halted, illegal, timeout};

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'h7f;
    #1;
    chk("reset_outs_a", 32'(all_outs), 32'd0);
    next_cycle();
    next_cycle();
    chk("reset_outs_b", 32'(all_outs), 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("release_state", 32'(state_out), 32'd0);
    chk("release_mem_req", 32'(mem_req), 32'd1);
  endtask

  // Run one instruction from FETCH to retirement. fw / mw are the wait cycles
  // before the memory answers the fetch and the data access.
  task automatic run_instr(input logic [6:0] op, input logic bc, input int fw, input int mw);
    int cyc = 0, req_idx = 0, waited = 0;
    int n_pcw = 0, n_rw = 0, n_req = 0, n_addr = 0, n_we = 0, n_irw = 0;
    int last_wb = 0;
    int e_cyc, e_pcw, e_rw, e_req, e_addr, e_we, e_wb;
    bit done = 0;
    opcode      = op;
    branch_cond = bc;
    while (!done && cyc < 64) begin
      if (mem_req) mem_ready = (waited >= ((req_idx == 0) ? fw : mw));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      n_pcw  += int'(pc_write);
      n_rw   += int'(reg_write);
      n_req  += int'(mem_req);
      n_addr += int'(addr_sel);
      n_we   += int'(mem_we);
      n_irw  += int'(ir_write);
      if (reg_write) last_wb = int'(wb_sel);
      if (mem_req && mem_ready) begin
        req_idx++;
        waited = 0;
      end else if (mem_req) begin
        waited++;
      end
      if (instr_retired) done = 1;
      next_cycle();
    end
    // reference model by instruction class
    e_pcw = 1; e_rw = 1; e_wb = 0; e_addr = 0; e_we = 0;
    e_cyc = 4 + fw;
    e_req = 1 + fw;
    case (op)
      OP_BRANCH: begin e_cyc = 3 + fw; e_pcw = 1 + int'(bc); e_rw = 0; end
      OP_LOAD:   begin e_cyc = 5 + fw + mw; e_req = 2 + fw + mw; e_addr = 1 + mw; e_wb = 1; end
      OP_STORE:  begin e_cyc = 4 + fw + mw; e_req = 2 + fw + mw; e_addr = 1 + mw; e_we = 1 + mw; e_rw = 0; end
      OP_JAL, OP_JALR: begin e_pcw = 2; e_wb = 2; end
      default: ;
    endcase
    chk($sformatf("op%02h_cycles", op), 32'(cyc), 32'(e_cyc));
    chk($sformatf("op%02h_pc_write_n", op), 32'(n_pcw), 32'(e_pcw));
    chk($sformatf("op%02h_reg_write_n", op), 32'(n_rw), 32'(e_rw));
    chk($sformatf("op%02h_mem_req_n", op), 32'(n_req), 32'(e_req));
    chk($sformatf("op%02h_addr_sel_n", op), 32'(n_addr), 32'(e_addr));
    chk($sformatf("op%02h_mem_we_n", op), 32'(n_we), 32'(e_we));
    chk($sformatf("op%02h_ir_write_n", op), 32'(n_irw), 32'd1);
    if (e_rw != 0) chk($sformatf("op%02h_wb_sel", op), 32'(last_wb), 32'(e_wb));
    chk($sformatf("op%02h_back_to_fetch", op), 32'(state_out), 32'd0);
    chk($sformatf("op%02h_flags", op), 32'({halted, illegal, timeout}), 32'd0);
  endtask

  task automatic run_halt(input logic [6:0] op, input logic exp_h, input logic exp_i);
    int act = 0;
    do_reset();
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    next_cycle();
    chk("halt_decode_state", 32'(state_out), 32'd1);
    next_cycle();
    chk("halt_state", 32'(state_out), 32'd5);
    chk("halt_flags", 32'({halted, illegal, timeout}), 32'({exp_h, exp_i, 1'b0}));
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      act += int'(mem_req) + int'(pc_write) + int'(reg_write) + int'(ir_write) + int'(instr_retired);
      next_cycle();
    end
    chk("halt_no_activity", 32'(act), 32'd0);
    chk("halt_state_hold", 32'(state_out), 32'd5);
    chk("halt_flags_hold", 32'({halted, illegal, timeout}), 32'({exp_h, exp_i, 1'b0}));
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Step 1: reset and a zero-wait ADD traced cycle by cycle
    do_reset();
    opcode    = OP_R;
    mem_ready = 1'b1;
    #1;
    chk("add_f_state", 32'(state_out), 32'd0);
    chk("add_f_strobes", 32'({mem_req, addr_sel, ir_write, pc_write}), 32'b1011);
    chk("add_f_alu", 32'({alu_a_sel, alu_b_sel, pc_src}), 32'b011000);
    next_cycle();
    chk("add_d_state", 32'(state_out), 32'd1);
    chk("add_d_alu", 32'({alu_a_sel, alu_b_sel}), 32'b1001);
    chk("add_d_strobes", 32'({mem_req, pc_write, reg_write}), 32'd0);
    next_cycle();
    chk("add_e_state", 32'(state_out), 32'd2);
    chk("add_e_alu", 32'({alu_a_sel, alu_b_sel, pc_write, reg_write}), 32'd0);
    next_cycle();
    chk("add_w_state", 32'(state_out), 32'd4);
    chk("add_w_strobes", 32'({reg_write, instr_retired, wb_sel, pc_write}), 32'b11000);
    next_cycle();
    chk("add_next_fetch", 32'(state_out), 32'd0);

    // Step 2: directed instructions from the test plan
    run_instr(OP_LOAD, 1'b0, 0, 3);
    run_instr(OP_BRANCH, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b0, 0, 0);
    run_instr(OP_STORE, 1'b0, 0, 0);
    run_instr(OP_STORE, 1'b0, 2, 3);

    // Step 3: BEQ taken, per-cycle view of EXEC
    opcode = OP_BRANCH; branch_cond = 1'b1; mem_ready = 1'b1;
    #1;
    next_cycle();
    next_cycle();
    chk("beq_exec", 32'({state_out, pc_write, pc_src, instr_retired}), 32'b010_1_01_1);

    // Step 4: randomized instruction stream
    next_cycle();
    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    // Step 5: illegal opcode and ECALL
    run_halt(7'h7f, 1'b0, 1'b1);
    run_halt(7'h73, 1'b1, 1'b0);

    // Step 6: fetch timeout after 16 stalled request cycles
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("to_wait_%0d", i), 32'({state_out, mem_req, timeout}), 32'b000_1_0);
      next_cycle();
    end
    chk("to_state", 32'(state_out), 32'd5);
    chk("to_flags", 32'({halted, illegal, timeout, mem_req}), 32'b0010);

    // Step 7: ready on the last allowed stall cycle wins over the timeout
    do_reset();
    opcode    = OP_R;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    chk("race_ir_write", 32'(ir_write), 32'd1);
    next_cycle();
    chk("race_state", 32'({state_out, timeout}), 32'b001_0);

    // Step 8: asynchronous reset in the middle of a stalled MEM access
    do_reset();
    opcode = OP_LOAD; mem_ready = 1'b1;
    #1;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    #1;
    chk("mid_mem_state", 32'({state_out, mem_req, addr_sel, mem_we}), 32'b011_1_1_0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_mem_reset_outs", 32'(all_outs), 32'd0);
    next_cycle();
    chk("mid_mem_reset_hold", 32'(all_outs), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_mem_resume", 32'({state_out, mem_req}), 32'b000_1);
    run_instr(OP_LOAD, 1'b0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences the RV32I datapath as a multi-cycle machine. Instruction fetch and data access share one unified memory port through a req/ready handshake. The block drives every datapath mux select and write strobe from the current state, IR opcode, branch condition and memory readiness, and flags halts, illegal opcodes and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, consecutive cycles with mem_req=1 and mem_ready=0 before a timeout halt (2..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
opcode  input  7  IR[6:0]
branch_cond  input  1  funct3 comparison result from the datapath (valid in EXEC)
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  load PC at the clock edge
ir_write  output  1  load IR and old_pc (the datapath latches the current PC into old_pc)
addr_sel  output  1  memory address: 0=PC, 1=ALUOut
mem_req  output  1  memory access request
mem_we  output  1  write access (only with mem_req)
alu_a_sel  output  2  00=rs1, 01=PC, 10=old_pc, 11=zero
alu_b_sel  output  2  00=rs2, 01=imm, 10=const 4
pc_src  output  2  00=ALU result (combinational), 01=ALUOut (registered)
wb_sel  output  2  00=ALUOut, 01=MDR, 10=link (old_pc+4)
reg_write  output  1  register file write
instr_retired  output  1  one-cycle pulse on the final cycle of each instruction
state_out  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
halted  output  1  sticky: HALT entered via ECALL/EBREAK
illegal  output  1  sticky: unsupported opcode
timeout  output  1  sticky: memory timeout

Behaviour:
- While reset is high: state=FETCH, sticky flags=0, timeout counter=0, and every output=0 (combinational outputs are gated). In the first cycle after release, mem_req=1.
- Any select or strobe not listed for a state is 0.
- FETCH: mem_req=1, addr_sel=0, alu_a_sel=01, alu_b_sel=10, pc_src=00. On mem_ready: ir_write=1, pc_write=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): alu_a_sel=10, alu_b_sel=01 (the branch/JAL target is latched in ALUOut).
  - Legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC.
  - 1110011 -> HALT, halted=1.
  - Any other opcode -> HALT, illegal=1.
- EXEC (1 cycle), by opcode:
  - R-type: a=00, b=00 -> WB.
  - I-ALU: a=00, b=01 -> WB.
  - LUI: a=11, b=01 -> WB.
  - AUIPC: a=10, b=01 -> WB.
  - LOAD/STORE: a=00, b=01 -> MEM.
  - BRANCH: a=00, b=00; pc_write=branch_cond, pc_src=01; instr_retired=1; -> FETCH.
  - JAL: pc_write=1, pc_src=01 -> WB.
  - JALR: a=00, b=01, pc_write=1, pc_src=00 (the datapath clears bit 0) -> WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. Wait for mem_ready.
  - LOAD: the datapath latches MDR on mem_ready -> WB.
  - STORE: instr_retired=1 on the mem_ready cycle -> FETCH.
- WB (1 cycle): reg_write=1, instr_retired=1 -> FETCH.
  - wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- HALT: all strobes 0, state_out=5, sticky flags hold. Leave only via reset.
- Handshake rules:
  - Once raised, mem_req, addr_sel and mem_we hold stable until mem_ready.
  - mem_ready is ignored when mem_req=0.
  - Zero-wait completion (ready in the first request cycle) is legal.
- Timeout: the counter increments each cycle mem_req=1 && mem_ready=0, and clears on mem_ready or state change. When it reaches TIMEOUT_CYCLES, go to HALT and set timeout=1. mem_ready arriving in that same cycle wins (no timeout).
- Zero-wait latencies: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.
- A reset asserted mid-instruction aborts it immediately and asynchronously: no partial reg_write or pc_write after the reset edge.

Test Plan:
- Reset, then ADD (0110011) with mem_ready tied 1 -> state_out 0,1,2,4,0; reg_write=1 and instr_retired=1 only in the WB cycle; pc_write once, in FETCH.
- LW (0000011), mem_ready low for 3 MEM cycles -> mem_req=1, addr_sel=1, mem_we=0 held for 4 cycles; then WB with wb_sel=01; 8 cycles total.
- BEQ with branch_cond=1 -> EXEC: pc_write=1, pc_src=01, instr_retired=1, 3 cycles. Repeat with branch_cond=0 -> pc_write=0 in EXEC.
- JAL (1101111) -> EXEC pc_write=1 pc_src=01; WB reg_write=1 wb_sel=10. SW (0100011) -> MEM mem_we=1, retire on mem_ready, no reg_write.
- Opcode 0x7F -> HALT after DECODE, illegal=1, no mem_req for 20 cycles. ECALL 0x73 -> halted=1, illegal=0.
- mem_ready stuck 0 in FETCH with TIMEOUT_CYCLES=16 -> HALT after 16 request cycles, timeout=1. Async reset mid-MEM -> all outputs 0 within the same cycle, flags cleared, FETCH resumes after release.
